// File: rtl/if_pkg.sv
// Shared types and constants for the IF-stage fetch unit and its skid FIFO.
package if_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam int PC_STEP = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            misaligned;
    } if_entry_t;

endpackage

// File: rtl/if_fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, instr, misaligned} entries toward ID.
// Flush beats push and pop; the head reads as all-zero while the FIFO is empty.
module if_fetch_fifo
    import if_pkg::*;
#(
    parameter int BUF_DEPTH = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             push,
    input  if_entry_t                        push_data,
    input  logic                             pop,
    input  logic                             flush,
    output logic [$clog2(BUF_DEPTH+1)-1:0]   count,
    output if_entry_t                        head
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    if_entry_t        mem_q [BUF_DEPTH];
    if_entry_t        mem_d [BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push && !flush;
        do_pop   = pop && !flush && (count_q != '0);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = next_ptr(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/if_fetch_unit.sv
// IF-stage fetch initiator: drives pc_req into imem, captures the word one cycle later
// and queues it toward ID. Optional IF_MISALIGN_CHECK_EN traps misaligned redirect targets.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] imem_pc,
    input  logic [XLEN-1:0] imem_instr,
    input  logic            stall_i,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc_plus4
`ifdef IF_MISALIGN_CHECK_EN
    ,
    output logic            if_misaligned
`endif
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    logic [XLEN-1:0]  pc_req_q, pc_req_d;
    logic [XLEN-1:0]  inflight_pc_q, inflight_pc_d;
    logic             inflight_q, inflight_d;
    logic [XLEN-1:0]  target_pc;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   occupancy;
    logic             pop, issue;
    if_entry_t        push_entry, fifo_head;

`ifdef IF_MISALIGN_CHECK_EN
    logic halt_q, halt_d;
    logic inflight_mis_q, inflight_mis_d;
`endif

    assign if_valid = (fifo_count != '0);
    assign pop      = if_valid && !stall_i;

    // Credits: FIFO entries plus the word still in imem must never exceed BUF_DEPTH.
    always_comb begin
        occupancy = {1'b0, fifo_count} + (CNT_W+1)'(inflight_q);
        issue     = (occupancy < (CNT_W+1)'(BUF_DEPTH)) ||
                    ((occupancy == (CNT_W+1)'(BUF_DEPTH)) && pop);

        push_entry.pc         = inflight_pc_q;
        push_entry.instr      = imem_instr;
        push_entry.misaligned = 1'b0;

`ifdef IF_MISALIGN_CHECK_EN
        target_pc = redirect_pc;
        if (halt_q) begin
            issue = 1'b0;
        end
        if (inflight_mis_q) begin
            push_entry.instr      = NOP_INSTR;
            push_entry.misaligned = 1'b1;
        end
`else
        target_pc = redirect_pc & ~XLEN'(3);
`endif

        pc_req_d      = pc_req_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        if (redirect_valid) begin
            pc_req_d = target_pc;
        end else if (issue) begin
            inflight_d    = 1'b1;
            inflight_pc_d = pc_req_q;
            pc_req_d      = pc_req_q + XLEN'(PC_STEP);
        end

`ifdef IF_MISALIGN_CHECK_EN
        halt_d         = halt_q;
        inflight_mis_d = 1'b0;
        if (redirect_valid) begin
            halt_d = 1'b0;
        end else if (issue && (pc_req_q[1:0] != 2'b00)) begin
            halt_d         = 1'b1;
            inflight_mis_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_req_q      <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            pc_req_q      <= pc_req_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

`ifdef IF_MISALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            halt_q         <= 1'b0;
            inflight_mis_q <= 1'b0;
        end else begin
            halt_q         <= halt_d;
            inflight_mis_q <= inflight_mis_d;
        end
    end
`endif

    // Redirect flushes; the word returning for a killed fetch is dropped via inflight<=0.
    if_fetch_fifo #(
        .BUF_DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight_q),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    assign imem_pc     = pc_req_q;
    assign if_pc       = fifo_head.pc;
    assign if_instr    = fifo_head.instr;
    assign if_pc_plus4 = fifo_head.pc + XLEN'(PC_STEP);

`ifdef IF_MISALIGN_CHECK_EN
    assign if_misaligned = fifo_head.misaligned;
`else
    logic misaligned_unused;
    assign misaligned_unused = fifo_head.misaligned;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed latency/stall/redirect/reset scenarios, then a
// randomized stall/redirect run scored against an in-order instruction-stream model.
`timescale 1ns/1ps
module tb_if_fetch_unit;
    import if_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall_i = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] imem_pc, imem_instr;
    logic        if_valid;
    logic [31:0] if_pc, if_instr, if_pc_plus4;
`ifdef IF_MISALIGN_CHECK_EN
    logic        if_misaligned;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // imem holds mem[k]=k and registers its output one cycle after sampling the address
    always @(posedge clk) imem_instr <= imem_pc >> 2;

    if_fetch_unit #(.RESET_PC(32'h0), .BUF_DEPTH(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .stall_i        (stall_i),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_pc_plus4    (if_pc_plus4)
`ifdef IF_MISALIGN_CHECK_EN
        ,
        .if_misaligned  (if_misaligned)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ends inside cycle 0 (first cycle out of reset), inputs idle.
    task automatic test_reset();
        reset = 1'b0; stall_i = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", if_valid); end
        checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %0h expected 0", if_pc); end
        checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %0h expected 0", if_instr); end
        checks++; if (imem_pc !== 32'h0) begin errors++; $display("FAIL reset_imem_pc: got %0h expected 0", imem_pc); end
`ifdef IF_MISALIGN_CHECK_EN
        checks++; if (if_misaligned !== 1'b0) begin errors++; $display("FAIL reset_mis: got %b expected 0", if_misaligned); end
`endif
    endtask

    // Cycles 0..5: first valid at cycle 2, then one instruction per cycle.
    task automatic test_stream();
        logic [31:0] e;
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (if_valid !== (k >= 2)) begin errors++; $display("FAIL stream_valid c%0d: got %b expected %b", k, if_valid, (k >= 2)); end
            if (k >= 2) begin
                e = 32'((k - 2) * 4);
                checks++; if (if_pc !== e) begin errors++; $display("FAIL stream_pc c%0d: got %0h expected %0h", k, if_pc, e); end
                checks++; if (if_instr !== (e >> 2)) begin errors++; $display("FAIL stream_instr c%0d: got %0h expected %0h", k, if_instr, e >> 2); end
                checks++; if (if_pc_plus4 !== e + 32'd4) begin errors++; $display("FAIL stream_plus4 c%0d: got %0h expected %0h", k, if_pc_plus4, e + 32'd4); end
            end
            tick();
        end
    endtask

    // Cycles 6..10 stalled: head frozen at 16; release continues 16,20,... without gaps.
    task automatic test_stall();
        logic [31:0] e;
        for (int k = 6; k < 17; k++) begin
            stall_i = (k <= 10);
            e = (k <= 11) ? 32'd16 : 32'(16 + (k - 11) * 4);
            checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL stall_valid c%0d: got %b expected 1", k, if_valid); end
            checks++; if (if_pc !== e) begin errors++; $display("FAIL stall_pc c%0d: got %0h expected %0h", k, if_pc, e); end
            checks++; if (if_instr !== (e >> 2)) begin errors++; $display("FAIL stall_instr c%0d: got %0h expected %0h", k, if_instr, e >> 2); end
            checks++; if ((imem_pc - if_pc) > 32'd8) begin errors++; $display("FAIL stall_window c%0d: imem_pc %0h head %0h", k, imem_pc, if_pc); end
            tick();
        end
        stall_i = 1'b0;
    endtask

    // Fill FIFO, redirect to 0x40: invalid for two cycles, then 0x40, 0x44.
    task automatic test_redirect_full();
        stall_i = 1'b1;
        repeat (3) tick();
        checks++; if ((imem_pc - if_pc) !== 32'd8) begin errors++; $display("FAIL rf_full: imem_pc %0h head %0h", imem_pc, if_pc); end
        stall_i = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect_valid = 1'b0;
        checks++; if (imem_pc !== 32'h40) begin errors++; $display("FAIL rf_imem_pc: got %0h expected 40", imem_pc); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rf_valid_r1: got %b expected 0", if_valid); end
        tick();
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rf_valid_r2: got %b expected 0", if_valid); end
        tick();
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h40) begin errors++; $display("FAIL rf_r3: got valid %b pc %0h expected 1/40", if_valid, if_pc); end
        checks++; if (if_instr !== 32'h10) begin errors++; $display("FAIL rf_r3_instr: got %0h expected 10", if_instr); end
        tick();
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h44) begin errors++; $display("FAIL rf_r4: got valid %b pc %0h expected 1/44", if_valid, if_pc); end
        tick();
    endtask

    // Redirect under stall, then redirect to 0x80: 0x40 never delivered.
    task automatic test_redirect_b2b();
        stall_i = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick();
        stall_i = 1'b0; redirect_pc = 32'h80;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL b2b_r1: got valid %b expected 0", if_valid); end
        checks++; if (imem_pc !== 32'h40) begin errors++; $display("FAIL b2b_imem1: got %0h expected 40", imem_pc); end
        tick();
        redirect_valid = 1'b0;
        checks++; if (imem_pc !== 32'h80) begin errors++; $display("FAIL b2b_imem2: got %0h expected 80", imem_pc); end
        for (int k = 0; k < 2; k++) begin
            checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap%0d: got valid %b pc %0h expected 0", k, if_valid, if_pc); end
            tick();
        end
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h80) begin errors++; $display("FAIL b2b_target: got valid %b pc %0h expected 1/80", if_valid, if_pc); end
        tick();
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h84) begin errors++; $display("FAIL b2b_next: got valid %b pc %0h expected 1/84", if_valid, if_pc); end
        tick();
    endtask

    // One-cycle reset with FIFO full: restart from RESET_PC.
    task automatic test_reset_midstream();
        stall_i = 1'b1;
        repeat (2) tick();
        checks++; if ((imem_pc - if_pc) !== 32'd8) begin errors++; $display("FAIL mr_full: imem_pc %0h head %0h", imem_pc, if_pc); end
        reset = 1'b0;
        tick();
        reset = 1'b1; stall_i = 1'b0;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL mr_valid: got %b expected 0", if_valid); end
        checks++; if (imem_pc !== 32'h0) begin errors++; $display("FAIL mr_imem_pc: got %0h expected 0", imem_pc); end
        checks++; if (if_pc !== 32'h0 || if_instr !== 32'h0) begin errors++; $display("FAIL mr_head: got pc %0h instr %0h expected 0/0", if_pc, if_instr); end
        tick();
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL mr_valid2: got %b expected 0", if_valid); end
        tick();
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin errors++; $display("FAIL mr_resume: got valid %b pc %0h expected 1/0", if_valid, if_pc); end
        tick();
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h4) begin errors++; $display("FAIL mr_resume2: got valid %b pc %0h expected 1/4", if_valid, if_pc); end
        tick();
    endtask

    task automatic test_misalign();
        redirect_valid = 1'b1; redirect_pc = 32'h42;
        tick();
        redirect_valid = 1'b0;
        tick();
        tick();
`ifdef IF_MISALIGN_CHECK_EN
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h42) begin errors++; $display("FAIL mis_entry: got valid %b pc %0h expected 1/42", if_valid, if_pc); end
        checks++; if (if_instr !== NOP_INSTR) begin errors++; $display("FAIL mis_nop: got %0h expected 13", if_instr); end
        checks++; if (if_misaligned !== 1'b1) begin errors++; $display("FAIL mis_flag: got %b expected 1", if_misaligned); end
        tick();
        for (int k = 0; k < 5; k++) begin
            checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL mis_halt%0d: got valid %b pc %0h expected 0", k, if_valid, if_pc); end
            tick();
        end
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        repeat (2) tick();
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_misaligned !== 1'b0) begin errors++; $display("FAIL mis_recover: got valid %b pc %0h mis %b expected 1/100/0", if_valid, if_pc, if_misaligned); end
        tick();
`else
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h40) begin errors++; $display("FAIL mis_aligned: got valid %b pc %0h expected 1/40", if_valid, if_pc); end
        checks++; if (if_instr !== 32'h10) begin errors++; $display("FAIL mis_instr: got %0h expected 10", if_instr); end
        tick();
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h44) begin errors++; $display("FAIL mis_next: got valid %b pc %0h expected 1/44", if_valid, if_pc); end
        tick();
`endif
    endtask

    // Model: ID must see an in-order PC stream; a redirect restarts it at the target,
    // a delivery happens on valid && !stall && !redirect, and empty gaps stay <= 2 cycles.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] rnd;
        logic        redir, stall;
        int          run;
        exp_pc = '0;
        run    = 0;
        for (int i = 0; i < 800; i++) begin
            redir = (i == 0) || ($urandom_range(0, 19) == 0);
            stall = ($urandom_range(0, 2) == 0);
            rnd   = $urandom;
            if (i > 0) begin
                if (if_valid) begin
                    checks++; if (if_pc !== exp_pc) begin errors++; $display("FAIL rnd_pc i%0d: got %0h expected %0h", i, if_pc, exp_pc); end
                    checks++; if (if_instr !== (exp_pc >> 2)) begin errors++; $display("FAIL rnd_instr i%0d: got %0h expected %0h", i, if_instr, exp_pc >> 2); end
                    checks++; if (if_pc_plus4 !== exp_pc + 32'd4) begin errors++; $display("FAIL rnd_plus4 i%0d: got %0h expected %0h", i, if_pc_plus4, exp_pc + 32'd4); end
                    checks++; if ((imem_pc - if_pc) > 32'd8) begin errors++; $display("FAIL rnd_window i%0d: imem_pc %0h head %0h", i, imem_pc, if_pc); end
`ifdef IF_MISALIGN_CHECK_EN
                    checks++; if (if_misaligned !== 1'b0) begin errors++; $display("FAIL rnd_mis i%0d: got %b expected 0", i, if_misaligned); end
`endif
                    run = 0;
                end else begin
                    run++;
                end
                checks++; if (run > 2) begin errors++; $display("FAIL rnd_gap i%0d: got %0d empty cycles expected at most 2", i, run); end
            end
            stall_i        = stall;
            redirect_valid = redir;
            redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | (rnd & 32'hC))
                                                         : (rnd & 32'hFFFF_FFFC);
            if (redir) begin
                exp_pc = redirect_pc;
                run    = 0;
            end else if (if_valid && !stall) begin
                exp_pc = exp_pc + 32'd4;
            end
            tick();
        end
        stall_i = 1'b0; redirect_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_full();
        test_redirect_b2b();
        test_reset_midstream();
        test_misalign();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
